// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath / decoder / memory bundle.
// master: the sequencer side. slave: the environment (memories, decoder, datapath).
interface instr_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    // Instruction memory
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    // Decoder / datapath view of the current instruction
    logic [3:0]         opcode;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc;

    // Decoder enables
    logic mem_load, mem_st, compare, reg_we, jump;
    logic jmp_rn, jump_b, jump_be, jump_a, jump_ae, jump_e;

    // Datapath results and targets
    logic               alu_lt;
    logic               alu_eq;
    logic [PC_W-1:0]    jmp_target;

    // Strobes and status
    logic alu_en;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    logic rf_we;
    logic flag_lt;
    logic flag_eq;
    logic mem_err;

    modport master (
        output imem_req, imem_addr, opcode, ir, pc,
        output alu_en, dmem_req, dmem_we, rf_we, flag_lt, flag_eq, mem_err,
        input  imem_ack, imem_rdata,
        input  mem_load, mem_st, compare, reg_we, jump,
        input  jmp_rn, jump_b, jump_be, jump_a, jump_ae, jump_e,
        input  alu_lt, alu_eq, jmp_target, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, opcode, ir, pc,
        input  alu_en, dmem_req, dmem_we, rf_we, flag_lt, flag_eq, mem_err,
        output imem_ack, imem_rdata,
        output mem_load, mem_st, compare, reg_we, jump,
        output jmp_rn, jump_b, jump_be, jump_a, jump_ae, jump_e,
        output alu_lt, alu_eq, jmp_target, dmem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Owns pc, ir and the compare flags; turns decoder enables into one-cycle strobes.
// Optional feature: define INSTR_SEQ_MEM_TIMEOUT_EN to bound memory waits with a
// TMO_W-bit counter and a sticky mem_err; otherwise requests wait indefinitely.
module instr_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int TMO_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    instr_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_flag_lt;
    logic               r_flag_eq;
    logic               r_imem_req;
    logic               r_alu_en;
    logic               r_dmem_req;
    logic               r_dmem_we;
    logic               r_rf_we;
    logic               w_cond;
    logic               w_jump_taken;

`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
    // Counter value seen in the last allowed wait cycle: it would hit all-ones this edge.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0]   r_tmo;
    logic               r_mem_err;
`endif

    // Jump condition from previously latched flags; kind bits resolved in fixed priority.
    always_comb begin
        w_cond = 1'b1;
        if (bus.jmp_rn) begin
            w_cond = 1'b1;
        end else if (bus.jump_b) begin
            w_cond = r_flag_lt;
        end else if (bus.jump_be) begin
            w_cond = r_flag_lt | r_flag_eq;
        end else if (bus.jump_a) begin
            w_cond = ~r_flag_lt & ~r_flag_eq;
        end else if (bus.jump_ae) begin
            w_cond = ~r_flag_lt;
        end else if (bus.jump_e) begin
            w_cond = r_flag_eq;
        end
        w_jump_taken = bus.jump & w_cond;
    end

    // Sequencer FSM; every strobe is registered and set on entry to its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StFetch;
            r_pc       <= '0;
            r_ir       <= '0;
            r_flag_lt  <= 1'b0;
            r_flag_eq  <= 1'b0;
            r_imem_req <= 1'b0;
            r_alu_en   <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= 1'b0;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
            r_tmo      <= '0;
            r_mem_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                StFetch: begin
                    // req is low here only after reset or a fetch timeout: (re)issue it
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
                        r_tmo      <= '0;
`endif
                    end else if (bus.imem_ack) begin
                        r_ir       <= bus.imem_rdata;
                        r_pc       <= r_pc + 1'b1;
                        r_imem_req <= 1'b0;
                        r_state    <= StDecode;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
                    end else if (r_tmo == TMO_LAST) begin
                        // Drop and retry at the same pc
                        r_imem_req <= 1'b0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_tmo      <= r_tmo + 1'b1;
`endif
                    end
                end
                StDecode: begin
                    r_alu_en <= 1'b1;
                    r_state  <= StExec;
                end
                StExec: begin
                    r_alu_en <= 1'b0;
                    if (bus.compare) begin
                        r_flag_lt <= bus.alu_lt;
                        r_flag_eq <= bus.alu_eq;
                    end
                    if (w_jump_taken) begin
                        r_pc <= bus.jmp_target;
                    end
                    if (bus.mem_load || bus.mem_st) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= bus.mem_st;
                        r_state    <= StMem;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
                        r_tmo      <= '0;
`endif
                    end else begin
                        r_rf_we <= bus.reg_we & ~bus.jump;
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_rf_we    <= bus.reg_we & ~bus.jump;
                        r_state    <= StWb;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
                    end else if (r_tmo == TMO_LAST) begin
                        // Abandon the access; write-back happens with rf_we held low
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_mem_err  <= 1'b1;
                        r_state    <= StWb;
                    end else begin
                        r_tmo      <= r_tmo + 1'b1;
`endif
                    end
                end
                StWb: begin
                    r_rf_we    <= 1'b0;
                    r_imem_req <= 1'b1;
                    r_state    <= StFetch;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
                    r_tmo      <= '0;
`endif
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.opcode    = r_ir[INSTR_W-1 -: 4];
    assign bus.ir        = r_ir;
    assign bus.pc        = r_pc;
    assign bus.alu_en    = r_alu_en;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.dmem_we   = r_dmem_we;
    assign bus.rf_we     = r_rf_we;
    assign bus.flag_lt   = r_flag_lt;
    assign bus.flag_eq   = r_flag_eq;
`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
    assign bus.mem_err   = r_mem_err;
`else
    assign bus.mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a small opcode table stands in for the
// control decoder, and a per-instruction reference model predicts pc, flags,
// strobe counts and cycle counts. Honours INSTR_SEQ_MEM_TIMEOUT_EN when defined.
module tb_instr_sequencer;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int TMO_W   = 4;

    localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_LD  = 4'd2,  OP_ST  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4,  OP_JMP = 4'd5,  OP_JRN = 4'd6,  OP_JB  = 4'd7;
    localparam logic [3:0] OP_JBE  = 4'd8,  OP_JA  = 4'd9,  OP_JAE = 4'd10, OP_JE  = 4'd11;
    localparam logic [3:0] OP_JMIX = 4'd12, OP_LDST = 4'd13;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic       m_lt;
    logic       m_eq;
    logic       m_err;

    always #5 clk = ~clk;

    instr_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in control decoder
    always_comb begin
        bus.mem_load = 1'b0; bus.mem_st  = 1'b0; bus.compare = 1'b0; bus.reg_we  = 1'b0;
        bus.jump     = 1'b0; bus.jmp_rn  = 1'b0; bus.jump_b  = 1'b0; bus.jump_be = 1'b0;
        bus.jump_a   = 1'b0; bus.jump_ae = 1'b0; bus.jump_e  = 1'b0;
        case (bus.opcode)
            OP_ADD:  bus.reg_we = 1'b1;
            OP_LD:   begin bus.mem_load = 1'b1; bus.reg_we = 1'b1; end
            OP_ST:   bus.mem_st = 1'b1;
            OP_LDST: begin bus.mem_load = 1'b1; bus.mem_st = 1'b1; bus.reg_we = 1'b1; end
            OP_CMP:  bus.compare = 1'b1;
            OP_JMP:  begin bus.jump = 1'b1; bus.reg_we = 1'b1; end
            OP_JRN:  begin bus.jump = 1'b1; bus.jmp_rn = 1'b1; bus.jump_e = 1'b1; end
            OP_JB:   begin bus.jump = 1'b1; bus.jump_b = 1'b1; end
            OP_JBE:  begin bus.jump = 1'b1; bus.jump_be = 1'b1; end
            OP_JA:   begin bus.jump = 1'b1; bus.jump_a = 1'b1; end
            OP_JAE:  begin bus.jump = 1'b1; bus.jump_ae = 1'b1; end
            OP_JE:   begin bus.jump = 1'b1; bus.jump_e = 1'b1; end
            OP_JMIX: begin bus.jump = 1'b1; bus.jump_b = 1'b1; bus.jump_e = 1'b1; end
            default: ;
        endcase
    end
    assign bus.jmp_target = bus.ir[7:0];

    // Fetch one instruction and follow it to the next fetch, checking against the model.
    task automatic run_instr(input logic [15:0] instr, input int iw, input int dw,
                             input logic lt, input logic eq);
        logic [3:0] op;
        logic [7:0] start_pc;
        bit   is_mem, exp_we, exp_rf, taken;
        int   exp_cyc, cyc, n, alu_n, rf_n, rf_at, dm_n, we_bad, fetch_bad;
        op       = instr[15:12];
        is_mem   = (op == OP_LD) || (op == OP_ST) || (op == OP_LDST);
        exp_we   = (op == OP_ST) || (op == OP_LDST);
        exp_rf   = (op == OP_ADD) || (op == OP_LD) || (op == OP_LDST);
        exp_cyc  = 4 + iw + (is_mem ? dw + 1 : 0);
        start_pc = m_pc;
        case (op)
            OP_JMP, OP_JRN: taken = 1'b1;
            OP_JB, OP_JMIX: taken = m_lt;
            OP_JBE:         taken = m_lt || m_eq;
            OP_JA:          taken = !m_lt && !m_eq;
            OP_JAE:         taken = !m_lt;
            OP_JE:          taken = m_eq;
            default:        taken = 1'b0;
        endcase
        m_pc = taken ? instr[7:0] : m_pc + 8'd1;
        if (op == OP_CMP) begin
            m_lt = lt;
            m_eq = eq;
        end

        n = 0;
        while (bus.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.imem_req !== 1'b1) begin
            bad++; $display("FAIL req_start: imem_req=%b want 1", bus.imem_req);
        end
        total++;
        if (bus.imem_addr !== start_pc) begin
            bad++; $display("FAIL imem_addr: got %0h want %0h", bus.imem_addr, start_pc);
        end

        bus.alu_lt = lt;
        bus.alu_eq = eq;
        fetch_bad  = 0;
        for (int k = 0; k <= iw; k++) begin
            if (bus.imem_req !== 1'b1) fetch_bad++;
            bus.imem_ack   = (k == iw);
            bus.imem_rdata = (k == iw) ? instr : 16'($urandom);
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;

        cyc = iw + 1; alu_n = 0; rf_n = 0; rf_at = -1; dm_n = 0; we_bad = 0;
        while (bus.imem_req !== 1'b1 && cyc < iw + 60) begin
            if (bus.alu_en === 1'b1) alu_n++;
            if (bus.rf_we === 1'b1) begin
                rf_n++;
                rf_at = cyc;
            end
            if (bus.dmem_req === 1'b1) begin
                if (bus.dmem_we !== exp_we) we_bad++;
                bus.dmem_ack = (dm_n == dw);
                dm_n++;
            end else begin
                bus.dmem_ack = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;

        total++;
        if (fetch_bad != 0) begin
            bad++; $display("FAIL fetch_hold op=%0h: req low %0d cycles want 0", op, fetch_bad);
        end
        total++;
        if (cyc != exp_cyc) begin
            bad++; $display("FAIL cycles op=%0h: got %0d want %0d", op, cyc, exp_cyc);
        end
        total++;
        if (alu_n != 1) begin
            bad++; $display("FAIL alu_en op=%0h: got %0d pulses want 1", op, alu_n);
        end
        total++;
        if (rf_n != int'(exp_rf)) begin
            bad++; $display("FAIL rf_we op=%0h: got %0d pulses want %0d", op, rf_n, exp_rf);
        end
        if (exp_rf) begin
            total++;
            if (rf_at != exp_cyc - 1) begin
                bad++; $display("FAIL rf_we_pos op=%0h: got %0d want %0d", op, rf_at, exp_cyc - 1);
            end
        end
        total++;
        if (dm_n != (is_mem ? dw + 1 : 0)) begin
            bad++; $display("FAIL dmem_req op=%0h: got %0d cycles want %0d", op, dm_n,
                            is_mem ? dw + 1 : 0);
        end
        total++;
        if (we_bad != 0) begin
            bad++; $display("FAIL dmem_we op=%0h: %0d wrong cycles want 0", op, we_bad);
        end
        total++;
        if (bus.pc !== m_pc) begin
            bad++; $display("FAIL pc op=%0h: got %0h want %0h", op, bus.pc, m_pc);
        end
        total++;
        if (bus.ir !== instr) begin
            bad++; $display("FAIL ir: got %0h want %0h", bus.ir, instr);
        end
        total++;
        if ({bus.flag_lt, bus.flag_eq} !== {m_lt, m_eq}) begin
            bad++; $display("FAIL flags op=%0h: got %b%b want %b%b", op, bus.flag_lt,
                            bus.flag_eq, m_lt, m_eq);
        end
        total++;
        if (bus.mem_err !== m_err) begin
            bad++; $display("FAIL mem_err: got %b want %b", bus.mem_err, m_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.imem_req, bus.alu_en, bus.dmem_req, bus.dmem_we, bus.rf_we} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000",
                            {bus.imem_req, bus.alu_en, bus.dmem_req, bus.dmem_we, bus.rf_we});
        end
        total++;
        if ({bus.pc, bus.ir} !== 24'h0) begin
            bad++; $display("FAIL reset_pc_ir: got %0h/%0h want 0/0", bus.pc, bus.ir);
        end
        total++;
        if ({bus.flag_lt, bus.flag_eq, bus.mem_err} !== 3'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000",
                            {bus.flag_lt, bus.flag_eq, bus.mem_err});
        end
        m_pc = 8'h00; m_lt = 1'b0; m_eq = 1'b0; m_err = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_add();
        run_instr({OP_ADD, 12'h123}, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_load_delay();
        run_instr({OP_LD, 12'h055}, 0, 3, 1'b0, 1'b0);
        run_instr({OP_ST, 12'h0AA}, 1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_compare_branch();
        run_instr({OP_CMP, 12'h000}, 0, 0, 1'b1, 1'b0);
        run_instr({OP_JB,  12'h040}, 0, 0, 1'b0, 1'b1);
        run_instr({OP_CMP, 12'h000}, 0, 0, 1'b0, 1'b0);
        run_instr({OP_JB,  12'h040}, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        run_instr({OP_JMP, 12'h0FE}, 0, 0, 1'b0, 1'b0);
        run_instr({OP_CMP, 12'h000}, 0, 0, 1'b0, 1'b1);
        run_instr({OP_NOP, 12'h000}, 1, 0, 1'b0, 1'b0);
        run_instr({OP_JMP, 12'h0FF}, 0, 0, 1'b0, 1'b0);
        run_instr({OP_JE,  12'h010}, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = {OP_LD, 12'h000};
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.dmem_req !== 1'b1) begin
            bad++; $display("FAIL mid_mem_enter: dmem_req=%b want 1", bus.dmem_req);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.dmem_req, bus.imem_req} !== 2'b00) begin
            bad++; $display("FAIL async_drop: dmem/imem req=%b want 00",
                            {bus.dmem_req, bus.imem_req});
        end
        total++;
        if (bus.pc !== 8'h00) begin
            bad++; $display("FAIL async_pc: got %0h want 0", bus.pc);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.dmem_ack = 1'b1;
        m_pc = 8'h00; m_lt = 1'b0; m_eq = 1'b0; m_err = 1'b0;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        total++;
        if ({bus.imem_req, bus.dmem_req, bus.rf_we} !== 3'b100) begin
            bad++; $display("FAIL post_reset_fetch: req/dreq/rf_we=%b want 100",
                            {bus.imem_req, bus.dmem_req, bus.rf_we});
        end
        run_instr({OP_ADD, 12'h000}, 0, 0, 1'b0, 1'b0);
    endtask

`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n, dm_n, rf_n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = {OP_LD, 12'h000};
        m_pc           = m_pc + 8'd1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        dm_n = 0; rf_n = 0;
        while (bus.dmem_req === 1'b1 && dm_n < 40) begin
            dm_n++;
            @(negedge clk);
            if (bus.rf_we === 1'b1) rf_n++;
        end
        total++;
        if (dm_n != (1 << TMO_W) - 1) begin
            bad++; $display("FAIL dmem_timeout: req held %0d want %0d", dm_n, (1 << TMO_W) - 1);
        end
        m_err = 1'b1;
        total++;
        if (bus.mem_err !== 1'b1) begin
            bad++; $display("FAIL mem_err_set: got %b want 1", bus.mem_err);
        end
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            if (bus.rf_we === 1'b1) rf_n++;
            n++;
        end
        total++;
        if (rf_n != 0) begin
            bad++; $display("FAIL timeout_rf_we: got %0d pulses want 0", rf_n);
        end
        // Fetch timeout: hold ack low, expect a drop and a retry at the same pc
        n = 0;
        while (bus.imem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != (1 << TMO_W) - 1) begin
            bad++; $display("FAIL imem_timeout: req held %0d want %0d", n, (1 << TMO_W) - 1);
        end
        @(negedge clk);
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
            bad++; $display("FAIL fetch_retry: req=%b addr=%0h want 1/%0h", bus.imem_req,
                            bus.imem_addr, m_pc);
        end
        run_instr({OP_ADD, 12'h000}, 0, 0, 1'b0, 1'b0);
    endtask
`else
    task automatic test_timeout();
        // Without the timeout feature a long data wait is simply held
        run_instr({OP_LD, 12'h000}, 0, 20, 1'b0, 1'b0);
        run_instr({OP_NOP, 12'h000}, 18, 0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack   = 1'b0;
        bus.alu_lt     = 1'b0;
        bus.alu_eq     = 1'b0;
        m_pc = 8'h00; m_lt = 1'b0; m_eq = 1'b0; m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_load_delay();
        test_compare_branch();
        test_wrap();
        test_random();
        test_reset_mid_mem();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
